// File: rtl/present_pkg.sv
// Shared types and default constants for the present-effects block.
package present_pkg;
  typedef enum logic [1:0] {
    P_LIFE   = 2'd0,
    P_ROPE   = 2'd1,
    P_FREEZE = 2'd2,
    P_SHIELD = 2'd3
  } present_t;

  typedef enum logic {
    T_IDLE   = 1'b0,
    T_ACTIVE = 1'b1
  } timer_state_t;

  localparam int LIVES_W         = 3;
  localparam int CNT_W           = 4;
  localparam int DEF_INIT_LIVES  = 3;
  localparam int DEF_MAX_LIVES   = 5;
  localparam int DEF_ROPE_TIME   = 8;
  localparam int DEF_FREEZE_TIME = 5;
  localparam int DEF_SHIELD_TIME = 6;
endpackage

// File: rtl/effect_timer.sv
// Seconds countdown for one timed effect: load restarts the full duration,
// clear forces IDLE and has priority over load and the second tick.
module effect_timer
  import present_pkg::*;
#(
  parameter int DURATION = DEF_ROPE_TIME
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             load,
  input  logic             secClk,
  input  logic             clear,
  output logic             active,
  output logic [CNT_W-1:0] count
);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DURATION);

  timer_state_t     state, state_next;
  logic [CNT_W-1:0] count_next;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= T_IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    if (clear) begin
      state_next = T_IDLE;
      count_next = '0;
    end else if (load) begin
      state_next = T_ACTIVE;
      count_next = LOAD_VAL;
    end else if (state == T_ACTIVE && secClk) begin
      if (count == CNT_W'(1)) begin
        state_next = T_IDLE;
        count_next = '0;
      end else begin
        count_next = count - CNT_W'(1);
      end
    end
  end

  assign active = (state == T_ACTIVE);
endmodule

// File: rtl/present_effects.sv
// Present collection effects: lives bookkeeping, game over, and timed effects.
// Macro PRESENT_SHIELD_EN enables the shield; otherwise type 3 pulses scoreBonus.
module present_effects
  import present_pkg::*;
#(
  parameter int INIT_LIVES  = DEF_INIT_LIVES,
  parameter int MAX_LIVES   = DEF_MAX_LIVES,
  parameter int ROPE_TIME   = DEF_ROPE_TIME,
  parameter int FREEZE_TIME = DEF_FREEZE_TIME,
  parameter int SHIELD_TIME = DEF_SHIELD_TIME
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               secClk,
  input  logic               gameRestart,
  input  logic               col_present,
  input  logic [1:0]         present_type,
  input  logic               playerHit,
  output logic [LIVES_W-1:0] lives,
  output logic               gameOver,
  output logic               ropeDouble,
  output logic               freezeBalls,
  output logic               shieldActive,
  output logic               scoreBonus
);
`ifdef PRESENT_SHIELD_EN
  localparam bit SHIELD_EN = 1'b1;
`else
  localparam bit SHIELD_EN = 1'b0;
`endif

  localparam logic [LIVES_W-1:0] INIT_L = LIVES_W'(INIT_LIVES);
  localparam logic [LIVES_W-1:0] MAX_L  = LIVES_W'(MAX_LIVES);

  logic               col_prev;
  logic               collect, life_ev, hit_dec, shield_absorb;
  logic               clear_all, bonus_next;
  logic [LIVES_W-1:0] lives_next;
  logic [2:0]         load, clear, active, fx;
  logic [CNT_W-1:0]   count [3];

  assign collect       = col_present && !col_prev && !gameOver;
  assign life_ev       = collect && (present_type == P_LIFE);
  assign shield_absorb = playerHit && shieldActive;
  assign hit_dec       = playerHit && !shieldActive && !gameOver;
  assign bonus_next    = !SHIELD_EN && collect && (present_type == P_SHIELD) && !gameRestart;

  // Simultaneous +1 and -1 cancel, which also covers the MAX_LIVES case.
  always_comb begin
    lives_next = lives;
    if (gameRestart)
      lives_next = INIT_L;
    else if (life_ev && !hit_dec)
      lives_next = (lives >= MAX_L) ? MAX_L : lives + LIVES_W'(1);
    else if (hit_dec && !life_ev && lives != '0)
      lives_next = lives - LIVES_W'(1);
  end

  // Timers go idle in the same cycle gameOver rises.
  assign clear_all = gameRestart || (lives_next == '0);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      col_prev   <= 1'b0;
      lives      <= INIT_L;
      gameOver   <= 1'b0;
      scoreBonus <= 1'b0;
    end else begin
      col_prev   <= gameRestart ? 1'b0 : col_present;
      lives      <= lives_next;
      gameOver   <= (lives_next == '0);
      scoreBonus <= bonus_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : gen_timer
      localparam int DUR = (gi == 0) ? ROPE_TIME : (gi == 1) ? FREEZE_TIME : SHIELD_TIME;
      assign load[gi]  = collect && (present_type == 2'(gi + 1)) && ((gi != 2) || SHIELD_EN);
      assign clear[gi] = clear_all || ((gi == 2) && shield_absorb);
      effect_timer #(.DURATION(DUR)) u_timer (
        .clk    (clk),
        .resetN (resetN),
        .load   (load[gi]),
        .secClk (secClk),
        .clear  (clear[gi]),
        .active (active[gi]),
        .count  (count[gi])
      );
      // ACTIVE always carries a nonzero count.
      assign fx[gi] = active[gi] && (count[gi] != '0);
    end
  endgenerate

  assign ropeDouble   = fx[0];
  assign freezeBalls  = fx[1];
  assign shieldActive = fx[2] && SHIELD_EN;
endmodule

// File: tb/tb_present_effects.sv
// Randomized and directed checks of present_effects against a seconds-remaining model.
module tb_present_effects;
  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       secClk = 1'b0, gameRestart = 1'b0, col_present = 1'b0, playerHit = 1'b0;
  logic [1:0] present_type = 2'd0;
  logic [2:0] lives;
  logic       gameOver, ropeDouble, freezeBalls, shieldActive, scoreBonus;

`ifdef PRESENT_SHIELD_EN
  localparam bit SH = 1'b1;
`else
  localparam bit SH = 1'b0;
`endif
  localparam int INIT = 3, MAXL = 5;
  localparam int DUR [3] = '{8, 5, 6};

  int n_checks = 0, n_pass = 0;
  int m_lives = INIT, m_rem [3] = '{0, 0, 0};
  bit m_go = 0, m_bonus = 0, m_prev = 0;

  present_effects dut (
    .clk(clk), .resetN(resetN), .secClk(secClk), .gameRestart(gameRestart),
    .col_present(col_present), .present_type(present_type), .playerHit(playerHit),
    .lives(lives), .gameOver(gameOver), .ropeDouble(ropeDouble),
    .freezeBalls(freezeBalls), .shieldActive(shieldActive), .scoreBonus(scoreBonus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    $display("[%0t] %s lives=%0d go=%0d rope=%0d frz=%0d shd=%0d bonus=%0d", $time, tag,
             lives, gameOver, ropeDouble, freezeBalls, shieldActive, scoreBonus);
    chk({tag, ".lives"}, 8'(lives), 8'(m_lives));
    chk({tag, ".gameOver"}, 8'(gameOver), 8'(m_go));
    chk({tag, ".ropeDouble"}, 8'(ropeDouble), 8'(m_rem[0] > 0));
    chk({tag, ".freezeBalls"}, 8'(freezeBalls), 8'(m_rem[1] > 0));
    chk({tag, ".shieldActive"}, 8'(shieldActive), 8'(m_rem[2] > 0));
    chk({tag, ".scoreBonus"}, 8'(scoreBonus), 8'(m_bonus));
  endtask

  task automatic model_reset();
    m_lives = INIT; m_go = 0; m_bonus = 0; m_prev = 0;
    for (int i = 0; i < 3; i++) m_rem[i] = 0;
  endtask

  // One clock of game rules in terms of lives and seconds left per effect.
  task automatic model_step(input bit col, input int typ, input bit hit, input bit sec, input bit rst);
    bit ev, shield_on, dec, life;
    if (rst) begin
      model_reset();
      return;
    end
    ev = col && !m_prev && !m_go;
    m_prev = col;
    shield_on = m_rem[2] > 0;
    for (int i = 0; i < 3; i++) if (sec && m_rem[i] > 0) m_rem[i]--;
    if (ev && (typ == 1 || typ == 2 || (typ == 3 && SH))) m_rem[typ-1] = DUR[typ-1];
    m_bonus = ev && typ == 3 && !SH;
    dec = 0;
    if (hit && !m_go) begin
      if (shield_on) m_rem[2] = 0;
      else dec = 1;
    end
    life = ev && typ == 0;
    if (life && !dec) m_lives = (m_lives + 1 > MAXL) ? MAXL : m_lives + 1;
    else if (dec && !life && m_lives > 0) m_lives--;
    m_go = (m_lives == 0);
    if (m_go) for (int i = 0; i < 3; i++) m_rem[i] = 0;
  endtask

  task automatic cyc(input string tag, input bit col, input int typ, input bit hit,
                     input bit sec, input bit rst);
    @(negedge clk);
    col_present = col; present_type = 2'(typ); playerHit = hit; secClk = sec; gameRestart = rst;
    @(posedge clk);
    model_step(col, typ, hit, sec, rst);
    #1;
    check_all(tag);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    resetN = 1'b1;

    // rope: one-cycle collision, then 8 second pulses
    cyc("rope_ev", 1, 1, 0, 0, 0);
    cyc("rope_fall", 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc("rope_sec", 0, 0, 0, 1, 0);
      cyc("rope_idle", 0, 0, 0, 0, 0);
    end

    // lives up to the ceiling, then saturation and cancelling hit
    for (int i = 0; i < 3; i++) begin
      cyc("life_ev", 1, 0, 0, 0, 0);
      cyc("life_fall", 0, 0, 0, 0, 0);
    end
    cyc("life_hit", 1, 0, 1, 0, 0);
    cyc("life_hit_fall", 0, 0, 0, 0, 0);

    // freeze down to 2, then reload on a secClk cycle
    cyc("frz_ev", 1, 2, 0, 0, 0);
    cyc("frz_fall", 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("frz_sec", 0, 0, 0, 1, 0);
    chk("frz_count2", 8'(dut.gen_timer[1].u_timer.count), 8'(m_rem[1]));
    cyc("frz_reload", 1, 2, 0, 1, 0);
    chk("frz_count5", 8'(dut.gen_timer[1].u_timer.count), 8'(m_rem[1]));
    cyc("frz_fall2", 0, 0, 0, 0, 0);

    // type 3 held for 10 cycles
    for (int i = 0; i < 10; i++) cyc("t3_hold", 1, 3, 0, 0, 0);
    cyc("t3_fall", 0, 0, 0, 0, 0);
    cyc("t3_hit", 0, 0, 1, 0, 0);
    cyc("t3_after", 0, 0, 0, 0, 0);

    // async reset during rope and freeze
    cyc("ar_rope", 1, 1, 0, 0, 0);
    cyc("ar_low", 0, 0, 0, 0, 0);
    cyc("ar_frz", 1, 2, 0, 0, 0);
    @(posedge clk);
    model_step(1, 2, 0, 0, 0);
    #2;
    resetN = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    @(negedge clk);
    col_present = 0; present_type = 0; playerHit = 0; secClk = 0; gameRestart = 0;
    resetN = 1'b1;
    cyc("post_reset", 0, 0, 0, 0, 0);

    // down to game over, ignored life, restart
    for (int i = 0; i < 3; i++) cyc("go_hit", 0, 0, 1, 0, 0);
    cyc("go_idle", 0, 0, 0, 0, 0);
    cyc("go_life", 1, 0, 0, 0, 0);
    cyc("go_rope", 0, 1, 1, 0, 0);
    cyc("go_restart", 0, 0, 0, 0, 1);
    cyc("go_after", 0, 0, 0, 0, 0);

    for (int i = 0; i < 2000; i++)
      cyc("rand", ($urandom % 3) != 0, int'($urandom % 4), ($urandom % 12) == 0,
          ($urandom % 4) == 0, ($urandom % 150) == 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
